// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   calc_aw()            : address width for a given register count
//   slice_lo()           : low bit of port <idx> inside a packed port bus
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int calc_aw(input int nregs);
      return $clog2(nregs);
   endfunction

   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_wr_en        : write-back enables, one per write port (clear busy)
//   i_wr_addr      : write-back addresses, port p at [p*AW +: AW]
//   i_busy_set     : mark i_busy_addr busy (producer issued)
//   i_busy_addr    : register to mark busy
//   o_busy_vec     : registered busy vector
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = calc_aw(NREGS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NWR-1:0]    i_wr_en,
   input  logic [NWR*AW-1:0] i_wr_addr,
   input  logic              i_busy_set,
   input  logic [AW-1:0]     i_busy_addr,
   output logic [NREGS-1:0]  o_busy_vec
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Clears are applied first so a same-cycle set on the same register wins:
   // a new producer issued while the old one was writing back.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int p = 0; p < NWR; p++) begin
         if (i_wr_en[p]) begin
            w_busy_nxt[i_wr_addr[slice_lo(p, AW) +: AW]] = 1'b0;
         end
      end
      if (i_busy_set) begin
         w_busy_nxt[i_busy_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy
// scoreboard.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_rs_addr      : read addresses, port k at [k*AW +: AW]
//   o_rs_data      : read data (combinational), port k at [k*XLEN +: XLEN]
//   o_rs_busy      : busy flag of each addressed register (combinational)
//   i_wr_en        : write enables; higher port index has priority
//   i_wr_addr      : write addresses, port p at [p*AW +: AW]
//   i_wr_data      : write data, port p at [p*XLEN +: XLEN]
//   i_busy_set     : mark i_busy_addr busy
//   i_busy_addr    : register to mark busy
//   o_busy_vec     : registered busy scoreboard
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = calc_aw(NREGS)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NRD*AW-1:0]   i_rs_addr,
   output logic [NRD*XLEN-1:0] o_rs_data,
   output logic [NRD-1:0]      o_rs_busy,
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   input  logic                i_busy_set,
   input  logic [AW-1:0]       i_busy_addr,
   output logic [NREGS-1:0]    o_busy_vec
);

   logic [XLEN-1:0]  r_mem [NREGS];
   logic [AW-1:0]    w_wr_addr [NWR];
   logic [XLEN-1:0]  w_wr_data [NWR];
   logic [NWR-1:0]   w_wr_ok;
   logic [NREGS-1:0] w_busy_vec;

   for (genvar p = 0; p < NWR; p++) begin : g_wr
      assign w_wr_addr[p] = i_wr_addr[slice_lo(p, AW) +: AW];
      assign w_wr_data[p] = i_wr_data[slice_lo(p, XLEN) +: XLEN];
      // Writes to x0 are squashed here so neither storage nor bypass sees them.
      assign w_wr_ok[p]   = i_wr_en[p] & ~((ZERO_REG != 0) && (w_wr_addr[p] == '0));
   end

   // Later loop iterations override earlier ones, so the highest-index port
   // wins when several ports target the same register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (w_wr_ok[p]) begin
               r_mem[w_wr_addr[p]] <= w_wr_data[p];
            end
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic            w_hit;
      logic [XLEN-1:0] w_byp;
      logic            w_zero;

      assign w_ra   = i_rs_addr[slice_lo(k, AW) +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

      always_comb begin
         w_hit = 1'b0;
         w_byp = '0;
         for (int p = 0; p < NWR; p++) begin
            if (w_wr_ok[p] && (w_wr_addr[p] == w_ra)) begin
               w_hit = 1'b1;
               w_byp = w_wr_data[p];
            end
         end
      end

      assign o_rs_data[slice_lo(k, XLEN) +: XLEN] =
         w_zero                      ? '0    :
         ((BYPASS != 0) && w_hit)    ? w_byp :
                                       r_mem[w_ra];

      // A register being written back this cycle is ready when bypassed.
      assign o_rs_busy[k] = w_busy_vec[w_ra] & ~((BYPASS != 0) && w_hit);
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr_en     (i_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_busy_set  (i_busy_set),
      .i_busy_addr (i_busy_addr),
      .o_busy_vec  (w_busy_vec)
   );

   assign o_busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 3;
   localparam int NWR   = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NRD*AW-1:0]   rs_addr = '0;
   logic [NWR-1:0]      wr_en = '0;
   logic [NWR*AW-1:0]   wr_addr = '0;
   logic [NWR*XLEN-1:0] wr_data = '0;
   logic                busy_set = 1'b0;
   logic [AW-1:0]       busy_addr = '0;

   logic [NRD*XLEN-1:0] rd_b, rd_n;
   logic [NRD-1:0]      rb_b, rb_n;
   logic [NREGS-1:0]    bv_b, bv_n;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                .ZERO_REG(1), .BYPASS(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rs_addr(rs_addr), .o_rs_data(rd_b),
      .o_rs_busy(rb_b), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_busy_set(busy_set), .i_busy_addr(busy_addr),
      .o_busy_vec(bv_b));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
                .ZERO_REG(1), .BYPASS(0)) dut_n (
      .i_clk(clk), .i_rst_n(rst_n), .i_rs_addr(rs_addr), .o_rs_data(rd_n),
      .o_rs_busy(rb_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_busy_set(busy_set), .i_busy_addr(busy_addr),
      .o_busy_vec(bv_n));

   typedef struct {
      bit                  chk;
      logic [NRD*XLEN-1:0] d_b, d_n;
      logic [NRD-1:0]      z_b, z_n;
      logic [NREGS-1:0]    vec;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference state: architectural register values and busy flags.
   logic [XLEN-1:0] m_mem [NREGS];
   bit              m_busy [NREGS];

   task automatic do_cycle(input bit rn, input logic [1:0] we,
                           input logic [4:0] wa0, input logic [31:0] wd0,
                           input logic [4:0] wa1, input logic [31:0] wd1,
                           input bit bs, input logic [4:0] ba,
                           input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [4:0] ra2, input bit chk);
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic [4:0]  ra [3];
      exp_t        e;
      wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
      ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
      @(posedge clk); #1;
      rst_n = rn; wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
      busy_set = bs; busy_addr = ba; rs_addr = {ra2, ra1, ra0};

      e.chk = chk;
      e.vec = '0;
      for (int r = 0; r < NREGS; r++) e.vec[r] = m_busy[r];
      for (int k = 0; k < NRD; k++) begin
         int hit = -1;
         for (int p = 0; p < NWR; p++)
            if (we[p] && wa[p] == ra[k] && ra[k] != 0) hit = p;
         if (ra[k] == 0) begin
            e.d_b[k*XLEN +: XLEN] = '0;
            e.d_n[k*XLEN +: XLEN] = '0;
         end else begin
            e.d_n[k*XLEN +: XLEN] = m_mem[ra[k]];
            e.d_b[k*XLEN +: XLEN] = (hit >= 0) ? wd[hit] : m_mem[ra[k]];
         end
         e.z_n[k] = m_busy[ra[k]];
         e.z_b[k] = m_busy[ra[k]] && (hit < 0);
      end
      q.push_back(e);

      // Advance the model to the state after this edge.
      if (!rn) begin
         for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (we[p]) begin
               if (wa[p] != 0) m_mem[wa[p]] = wd[p];
               m_busy[wa[p]] = 1'b0;
            end
         end
         if (bs && ba != 0) m_busy[ba] = 1'b1;
      end
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
      do_cycle(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, a0, a1, a2, 1);
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, 31));
   endfunction

   // Monitor: outputs are combinational and present every cycle, so each
   // queued expectation is consumed at the falling edge that follows it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               checks += 6;
               if (rd_b !== e.d_b) begin
                  errors++;
                  $display("FAIL rd_bypass act=%h exp=%h", rd_b, e.d_b);
               end
               if (rd_n !== e.d_n) begin
                  errors++;
                  $display("FAIL rd_nobypass act=%h exp=%h", rd_n, e.d_n);
               end
               if (rb_b !== e.z_b) begin
                  errors++;
                  $display("FAIL rs_busy_bypass act=%b exp=%b", rb_b, e.z_b);
               end
               if (rb_n !== e.z_n) begin
                  errors++;
                  $display("FAIL rs_busy_nobypass act=%b exp=%b", rb_n, e.z_n);
               end
               if (bv_b !== e.vec) begin
                  errors++;
                  $display("FAIL busy_vec_bypass act=%h exp=%h", bv_b, e.vec);
               end
               if (bv_n !== e.vec) begin
                  errors++;
                  $display("FAIL busy_vec_nobypass act=%h exp=%h", bv_n, e.vec);
               end
            end
         end
      end
   end

   initial begin
      for (int r = 0; r < NREGS; r++) begin
         m_mem[r] = '0;
         m_busy[r] = 1'b0;
      end
      // Initial reset: pre-reset contents are undefined, so not checked.
      do_cycle(0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 5'd0, 0);
      // Preload x5 and mark x8 busy, then reset with a write to x6 pending.
      do_cycle(1, 2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 1, 5'd8, 5'd5, 5'd8, 5'd0, 1);
      rd(5'd5, 5'd8, 5'd6);
      do_cycle(0, 2'b01, 5'd6, 32'h55, 5'd0, 32'h0, 1, 5'd9, 5'd5, 5'd6, 5'd8, 1);
      for (int a = 0; a < NREGS; a += 3)
         rd(5'(a), 5'(a + 1), 5'(a + 2));
      // Same-cycle bypass of x7.
      do_cycle(1, 2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd7, 5'd0, 1);
      rd(5'd0, 5'd7, 5'd0);
      // Write conflict on x3: port 1 wins.
      do_cycle(1, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 0, 5'd0, 5'd3, 5'd3, 5'd3, 1);
      rd(5'd3, 5'd0, 5'd0);
      // x0 is hardwired.
      do_cycle(1, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0, 5'd0, 1);
      rd(5'd0, 5'd0, 5'd0);
      // Scoreboard on x9.
      do_cycle(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 5'd0, 1);
      rd(5'd9, 5'd9, 5'd0);
      do_cycle(1, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd0, 5'd9, 1);
      rd(5'd9, 5'd0, 5'd0);
      do_cycle(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 5'd0, 1);
      do_cycle(1, 2'b01, 5'd9, 32'h98, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 5'd0, 1);
      rd(5'd9, 5'd0, 5'd0);
      // Two distinct writes read on three ports in the same cycle.
      do_cycle(1, 2'b11, 5'd1, 32'hA, 5'd2, 32'hB, 0, 5'd0, 5'd1, 5'd2, 5'd0, 1);
      rd(5'd1, 5'd2, 5'd0);

      for (int n = 0; n < 3000; n++) begin
         do_cycle(($urandom_range(0, 63) != 0),
                  2'($urandom_range(0, 3)),
                  rnd_addr(), $urandom(), rnd_addr(), $urandom(),
                  ($urandom_range(0, 2) == 0), rnd_addr(),
                  rnd_addr(), rnd_addr(), rnd_addr(), 1);
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain act=%0d exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
